// File: rtl/hazard_pkg.sv
// Shared types and encodings for the multi-cycle hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMdBusy  = 2'd1,
    StMemWait = 2'd2
  } hz_state_e;

  localparam logic [1:0] RES_LOAD = 2'b01;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_fwd_sel.sv
// E-stage operand forward select for one source register; M beats W, x0 never forwards.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              reg_write_m_i,
  input  logic              reg_write_w_i,
  output logic [1:0]        sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_i)) begin
      sel_o = FWD_M;
    end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) begin
      sel_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// Multi-cycle hazard controller: load-use/branch/forwarding plus a mul/div and memory-wait FSM.
// Optional saturating performance counters are built when HAZARD_PERF_EN is defined.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MD_LAT      = 4,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_D,
  input  logic [REG_AW-1:0] rs2_D,
  input  logic [REG_AW-1:0] rs1_E,
  input  logic [REG_AW-1:0] rs2_E,
  input  logic [REG_AW-1:0] rd_E,
  input  logic [REG_AW-1:0] rd_M,
  input  logic [REG_AW-1:0] rd_W,
  input  logic              RegWrite_M,
  input  logic              RegWrite_W,
  input  logic [1:0]        ResultSrc_E,
  input  logic              MulDiv_E,
  input  logic              MemReq_M,
  input  logic              DMemReady,
  input  logic              PCSrc_E,
  output logic              Stall_F,
  output logic              Stall_D,
  output logic              Stall_E,
  output logic              Stall_M,
  output logic              Flush_D,
  output logic              Flush_E,
  output logic              Flush_M,
  output logic              Flush_W,
  output logic [1:0]        Select_A,
  output logic [1:0]        Select_B,
  output logic              Select_C,
  output logic              Select_D,
  output logic              MD_Busy,
  output logic              Mem_Err,
  output logic [CNT_W-1:0]  Stall_Cnt,
  output logic [CNT_W-1:0]  Flush_Cnt
);

  localparam int unsigned MdW  = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
  localparam int unsigned MemW = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
  localparam logic [MdW-1:0]  MdLoad = MdW'(MD_LAT - 2);
  localparam logic [MemW-1:0] MemTo  = MemW'(MEM_TIMEOUT);

  hz_state_e       state_q, state_d;
  logic [MdW-1:0]  md_cnt_q, md_cnt_d;
  logic [MemW-1:0] mem_cnt_q, mem_cnt_d;
  logic            md_busy_q, md_busy_d;
  logic            mem_err_q, mem_err_d;

  logic mem_stall, md_stall, lu_hit, lu_stall, branch;

  always_comb begin
    mem_stall = MemReq_M & ~DMemReady;
    md_stall  = ~mem_stall & (((state_q != StMdBusy) & MulDiv_E) |
                              ((state_q == StMdBusy) & (md_cnt_q != '0)));
    lu_hit    = (ResultSrc_E == RES_LOAD) & (rd_E != '0) & ((rd_E == rs1_D) | (rd_E == rs2_D));
    // A taken branch squashes the dependent instruction, so the load-use bubble is moot.
    lu_stall  = lu_hit & ~PCSrc_E & ~mem_stall & ~md_stall;

    Stall_F = mem_stall | md_stall | lu_stall;
    Stall_D = mem_stall | md_stall | lu_stall;
    Stall_E = mem_stall | md_stall;
    Stall_M = mem_stall;
    branch  = PCSrc_E & ~Stall_E;
    Flush_D = branch;
    Flush_E = branch | lu_stall;
    Flush_M = md_stall;
    Flush_W = mem_stall;
  end

  always_comb begin
    state_d   = state_q;
    md_cnt_d  = md_cnt_q;
    mem_cnt_d = '0;
    unique case (state_q)
      // The release cycle of a memory wait may start a mul/div held in E.
      StIdle, StMemWait: begin
        if (mem_stall) begin
          state_d = StMemWait;
        end else if (MulDiv_E) begin
          state_d  = StMdBusy;
          md_cnt_d = MdLoad;
        end else begin
          state_d = StIdle;
        end
      end
      StMdBusy: begin
        if (!mem_stall) begin
          if (md_cnt_q != '0) md_cnt_d = md_cnt_q - 1'b1;
          else                state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if ((state_q == StMemWait) && mem_stall) begin
      mem_cnt_d = (mem_cnt_q == MemTo) ? mem_cnt_q : mem_cnt_q + 1'b1;
    end
    mem_err_d = mem_err_q | (mem_cnt_d == MemTo);
    md_busy_d = (state_d == StMdBusy) & (md_cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      md_cnt_q  <= '0;
      mem_cnt_q <= '0;
      md_busy_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      md_cnt_q  <= md_cnt_d;
      mem_cnt_q <= mem_cnt_d;
      md_busy_q <= md_busy_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign MD_Busy = md_busy_q;
  assign Mem_Err = mem_err_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (Stall_F && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (Flush_D && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Stall_Cnt = stall_cnt_q;
  assign Flush_Cnt = flush_cnt_q;
`else
  assign Stall_Cnt = '0;
  assign Flush_Cnt = '0;
`endif

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_i          (rs1_E),
    .rd_m_i        (rd_M),
    .rd_w_i        (rd_W),
    .reg_write_m_i (RegWrite_M),
    .reg_write_w_i (RegWrite_W),
    .sel_o         (Select_A)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_i          (rs2_E),
    .rd_m_i        (rd_M),
    .rd_w_i        (rd_W),
    .reg_write_m_i (RegWrite_M),
    .reg_write_w_i (RegWrite_W),
    .sel_o         (Select_B)
  );

  assign Select_C = RegWrite_W & (rd_W != '0) & (rd_W == rs1_D);
  assign Select_D = RegWrite_W & (rd_W != '0) & (rd_W == rs2_D);

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed plus random checks of hazard_unit_mc against a cycle-level behavioural model.
module tb_hazard_unit_mc;

  localparam int unsigned AW  = 5;
  localparam int unsigned LAT = 4;
  localparam int unsigned TO  = 2;
  localparam int unsigned CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic          RegWrite_M, RegWrite_W, MulDiv_E, MemReq_M, DMemReady, PCSrc_E;
  logic [1:0]    ResultSrc_E;
  logic          Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_M, Flush_W;
  logic [1:0]    Select_A, Select_B;
  logic          Select_C, Select_D, MD_Busy, Mem_Err;
  logic [CW-1:0] Stall_Cnt, Flush_Cnt;

  int n_vec = 0;
  int n_err = 0;

  // Model state: md_owed < 0 means no mul/div in flight, else stall cycles still owed.
  int md_owed = -1;
  bit waiting = 0;
  int mcnt    = 0;
  bit err     = 0;
  int scnt    = 0;
  int fcnt    = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(AW), .MD_LAT(LAT), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
    .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W), .ResultSrc_E(ResultSrc_E),
    .MulDiv_E(MulDiv_E), .MemReq_M(MemReq_M), .DMemReady(DMemReady), .PCSrc_E(PCSrc_E),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
    .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_M(Flush_M), .Flush_W(Flush_W),
    .Select_A(Select_A), .Select_B(Select_B), .Select_C(Select_C), .Select_D(Select_D),
    .MD_Busy(MD_Busy), .Mem_Err(Mem_Err), .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input logic [AW-1:0] rs, input logic [AW-1:0] rd, input logic we);
    return we && (rd != 0) && (rd == rs);
  endfunction

  function automatic logic [1:0] fwd(input logic [AW-1:0] rs);
    if (hit(rs, rd_M, RegWrite_M)) return 2'b10;
    if (hit(rs, rd_W, RegWrite_W)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clr();
    {rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W} = '0;
    {RegWrite_M, RegWrite_W, MulDiv_E, MemReq_M, PCSrc_E} = '0;
    DMemReady   = 1'b1;
    ResultSrc_E = 2'b00;
  endtask

  // Check the current cycle against the model, then let one clock edge pass.
  task automatic tick();
    bit ms, md, lu, se, br;
    int sat;
    #1;
    if (!rst_n) begin
      md_owed = -1; waiting = 0; mcnt = 0; err = 0; scnt = 0; fcnt = 0;
    end
    ms = MemReq_M && !DMemReady;
    md = !ms && ((md_owed < 0 && MulDiv_E) || md_owed > 0);
    lu = !ms && !md && !PCSrc_E && (ResultSrc_E == 2'b01) && (rd_E != 0) &&
         ((rd_E == rs1_D) || (rd_E == rs2_D));
    se = ms || md;
    br = PCSrc_E && !se;
    chk("Stall_F", Stall_F, ms | md | lu);
    chk("Stall_D", Stall_D, ms | md | lu);
    chk("Stall_E", Stall_E, se);
    chk("Stall_M", Stall_M, ms);
    chk("Flush_D", Flush_D, br);
    chk("Flush_E", Flush_E, br | lu);
    chk("Flush_M", Flush_M, md);
    chk("Flush_W", Flush_W, ms);
    chk("Select_A", Select_A, fwd(rs1_E));
    chk("Select_B", Select_B, fwd(rs2_E));
    chk("Select_C", Select_C, hit(rs1_D, rd_W, RegWrite_W));
    chk("Select_D", Select_D, hit(rs2_D, rd_W, RegWrite_W));
    chk("MD_Busy", MD_Busy, md_owed > 0);
    chk("Mem_Err", Mem_Err, err);
`ifdef HAZARD_PERF_EN
    chk("Stall_Cnt", Stall_Cnt, scnt);
    chk("Flush_Cnt", Flush_Cnt, fcnt);
`else
    chk("Stall_Cnt", Stall_Cnt, 0);
    chk("Flush_Cnt", Flush_Cnt, 0);
`endif
    if (rst_n) begin
      sat = (1 << CW) - 1;
      if ((ms || md || lu) && scnt < sat) scnt++;
      if (br && fcnt < sat) fcnt++;
      if (waiting && ms) mcnt = (mcnt < TO) ? mcnt + 1 : mcnt;
      else mcnt = 0;
      if (mcnt == TO) err = 1;
      waiting = ms && (md_owed < 0);
      if (!ms) begin
        if (md_owed < 0 && MulDiv_E) md_owed = LAT - 2;
        else if (md_owed > 0) md_owed--;
        else if (md_owed == 0) md_owed = -1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    clr();
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();

    // Load-use hit, then x0 destination must not stall.
    ResultSrc_E = 2'b01; rd_E = 5; rs1_D = 5;
    #1 chk("lu_stall", Stall_F, 1'b1);
    tick();
    ResultSrc_E = 2'b00;
    tick();
    ResultSrc_E = 2'b01; rd_E = 0; rs1_D = 0;
    #1 chk("lu_x0", Stall_F, 1'b0);
    tick();
    clr();

    // Mul/div: three stall cycles, release with MulDiv_E still high, no retrigger.
    MulDiv_E = 1'b1;
    repeat (3) tick();
    #1 chk("md_release", Stall_F, 1'b0);
    tick();
    MulDiv_E = 1'b0;
    tick();

    // Branch held in E during a mul/div stall.
    MulDiv_E = 1'b1; PCSrc_E = 1'b1;
    repeat (3) tick();
    #1 chk("br_release", Flush_D, 1'b1);
    tick();
    clr();
    tick();

    // Branch beats a coincident load-use.
    ResultSrc_E = 2'b01; rd_E = 3; rs2_D = 3; PCSrc_E = 1'b1;
    tick();
    clr();

    // Memory wait of three cycles trips the short timeout, which stays set.
    MemReq_M = 1'b1; DMemReady = 1'b0;
    repeat (3) tick();
    DMemReady = 1'b1;
    tick();
    clr();
    chk("mem_err_set", Mem_Err, 1'b1);
    repeat (2) tick();
    chk("mem_err_sticky", Mem_Err, 1'b1);

    // Forwarding priority.
    rs1_E = 7; rd_M = 7; rd_W = 7; RegWrite_M = 1'b1; RegWrite_W = 1'b1;
    #1 chk("fwd_m", Select_A, 2'b10);
    tick();
    RegWrite_M = 1'b0;
    #1 chk("fwd_w", Select_A, 2'b01);
    tick();
    clr();

    // Memory stall landing inside a mul/div freezes it.
    MulDiv_E = 1'b1;
    tick();
    MemReq_M = 1'b1; DMemReady = 1'b0;
    repeat (2) tick();
    DMemReady = 1'b1;
    repeat (3) tick();
    clr();
    tick();

    // Long stall saturates the stall counter, then reset lands mid-stall.
    MemReq_M = 1'b1; DMemReady = 1'b0;
    repeat (20) tick();
`ifdef HAZARD_PERF_EN
    chk("stall_sat", Stall_Cnt, 15);
`endif
    rst_n = 1'b0;
    #1 chk("rst_busy", MD_Busy, 1'b0);
    chk("rst_err", Mem_Err, 1'b0);
    chk("rst_cnt", Stall_Cnt, 0);
    tick();
    rst_n = 1'b1;
    clr();
    tick();

    for (int i = 0; i < 2000; i++) begin
      rs1_D = AW'($urandom_range(0, 7));
      rs2_D = AW'($urandom_range(0, 7));
      rs1_E = AW'($urandom_range(0, 7));
      rs2_E = AW'($urandom_range(0, 7));
      rd_E  = AW'($urandom_range(0, 7));
      rd_M  = AW'($urandom_range(0, 7));
      rd_W  = AW'($urandom_range(0, 7));
      RegWrite_M  = 1'($urandom_range(0, 1));
      RegWrite_W  = 1'($urandom_range(0, 1));
      ResultSrc_E = 2'($urandom_range(0, 3));
      MulDiv_E    = ($urandom_range(0, 5) == 0);
      MemReq_M    = ($urandom_range(0, 3) == 0);
      DMemReady   = 1'($urandom_range(0, 1));
      PCSrc_E     = ($urandom_range(0, 4) == 0);
      rst_n       = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
